// File: rtl/sad_pkg.sv
// sad_pkg: shared state type and default sizing for the SAD motion-estimation controller
package sad_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, ACK, RUN, CMP, DONE} sad_me_state_t;
  localparam int SAD_W_DEF = 32;
  localparam int NCAND_DEF = 16;
  localparam logic [SAD_W_DEF-1:0] SAD_ONES = '1;
endpackage

// File: rtl/sad_min_track.sv
// sad_min_track: running minimum of SAD results; strict less-than so ties keep the earliest index
module sad_min_track import sad_pkg::*; #(
  parameter int SAD_W = SAD_W_DEF,
  parameter int IW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             upd,
  input  logic [SAD_W-1:0] val,
  input  logic [IW-1:0]    idx,
  output logic [SAD_W-1:0] best_sad,
  output logic [IW-1:0]    best_idx
);
  always_ff @(posedge clk)
    if (rst || clr) begin
      best_sad <= '1;
      best_idx <= '0;
    end else if (upd && val < best_sad) begin
      best_sad <= val;
      best_idx <= idx;
    end
endmodule

// File: rtl/sad_me_ctrl.sv
// sad_me_ctrl: sequences NCAND SAD engine runs and reports the minimum-SAD candidate
// SAD_ME_EARLY_EXIT_EN: a zero SAD ends the search immediately
module sad_me_ctrl import sad_pkg::*; #(
  parameter int NCAND = NCAND_DEF,
  parameter int SAD_W = SAD_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     sad_busy_i,
  input  logic [SAD_W-1:0]         sad_dt_i,
  output logic                     sad_enb_o,
  output logic [$clog2(NCAND)-1:0] cand_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(NCAND)-1:0] best_idx_o,
  output logic [SAD_W-1:0]         best_sad_o
);
  localparam int IW = $clog2(NCAND);
  sad_me_state_t state;
  logic last;
`ifdef SAD_ME_EARLY_EXIT_EN
  assign last = (cand_o == IW'(NCAND - 1)) || (sad_dt_i == '0);
`else
  assign last = cand_o == IW'(NCAND - 1);
`endif
  sad_min_track #(.SAD_W(SAD_W), .IW(IW)) u_track (
    .clk      (clk_i),
    .rst      (rst_i),
    .clr      (state == IDLE && start_i),
    .upd      (state == CMP),
    .val      (sad_dt_i),
    .idx      (cand_o),
    .best_sad (best_sad_o),
    .best_idx (best_idx_o)
  );
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state     <= IDLE;
      cand_o    <= '0;
      sad_enb_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      sad_enb_o <= 1'b0;
      done_o    <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          cand_o    <= '0;
          sad_enb_o <= 1'b1;
          busy_o    <= 1'b1;
          state     <= LAUNCH;
        end
        LAUNCH: state <= ACK;
        ACK: if (sad_busy_i) state <= RUN;
        RUN: if (!sad_busy_i) state <= CMP;
        CMP: if (last) begin
          done_o <= 1'b1;
          state  <= DONE;
        end else begin
          cand_o    <= cand_o + IW'(1);
          sad_enb_o <= 1'b1;
          state     <= LAUNCH;
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sad_me_ctrl.sv
// tb_sad_me_ctrl: scoreboard bench for sad_me_ctrl with a behavioural SAD engine (NCAND=4)
module tb_sad_me_ctrl;
  import sad_pkg::*;
  typedef struct {logic [1:0] idx; logic [31:0] sad; int n;} exp_t;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic sad_busy_i, sad_enb_o, busy_o, done_o;
  logic [31:0] sad_dt_i, best_sad_o;
  logic [1:0] cand_o, best_idx_o;
  logic [31:0] sads [4];
  logic [7:0] eng_cnt;
  exp_t q[$];
  int n_cmp = 0, n_err = 0, enb_cnt = 0, done_cnt = 0;

  sad_me_ctrl #(.NCAND(4), .SAD_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sad_busy_i(sad_busy_i),
    .sad_dt_i(sad_dt_i), .sad_enb_o(sad_enb_o), .cand_o(cand_o), .busy_o(busy_o),
    .done_o(done_o), .best_idx_o(best_idx_o), .best_sad_o(best_sad_o)
  );

  always #5 clk_i = ~clk_i;

  // engine: busy rises the cycle after enb and stays high 256 cycles
  always @(posedge clk_i)
    if (rst_i) begin
      sad_busy_i <= 1'b0;
      eng_cnt    <= '0;
      sad_dt_i   <= '0;
    end else if (sad_enb_o) begin
      sad_busy_i <= 1'b1;
      eng_cnt    <= 8'd255;
      sad_dt_i   <= sads[cand_o];
    end else if (sad_busy_i) begin
      if (eng_cnt == 0) sad_busy_i <= 1'b0;
      else eng_cnt <= eng_cnt - 8'd1;
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    e.idx = 2'd0;
    e.sad = SAD_ONES;
    e.n = 0;
    for (int i = 0; i < 4; i++) begin
      e.n++;
      if (sads[i] < e.sad) begin
        e.sad = sads[i];
        e.idx = 2'(i);
      end
`ifdef SAD_ME_EARLY_EXIT_EN
      if (sads[i] == 0) break;
`endif
    end
    return e;
  endfunction

  always @(negedge clk_i)
    if (rst_i) enb_cnt = 0;
    else begin
      if (sad_enb_o) enb_cnt++;
      if (done_o) begin
        exp_t e;
        done_cnt++;
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("best_idx", best_idx_o, e.idx);
          chk("best_sad", best_sad_o, e.sad);
          chk("launches", enb_cnt, e.n);
        end
        enb_cnt = 0;
      end
    end

  task automatic start_search(input logic [31:0] a, b, c, d, input bit expect_done);
    sads = '{a, b, c, d};
    @(negedge clk_i);
    start_i = 1'b1;
    if (expect_done) q.push_back(model());
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && !done_o; k++) @(negedge clk_i);
    if (!done_o) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_cand(input logic [1:0] c);
    for (int k = 0; k < 3000 && !(cand_o == c && sad_busy_i); k++) @(negedge clk_i);
    if (!(cand_o == c && sad_busy_i)) chk("cand_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_enb"}, sad_enb_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_cand"}, cand_o, 0);
    chk({tag, "_bidx"}, best_idx_o, 0);
    chk({tag, "_bsad"}, best_sad_o, SAD_ONES);
  endtask

  initial begin
    int d0;
    sads = '{default: 32'd0};
    repeat (2) @(negedge clk_i);
    start_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk_reset_vals("rst");
    rst_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("idle_busy", busy_o, 0);

    start_search(40, 12, 30, 12, 1);
    wait_done();
    repeat (3) @(negedge clk_i);
    chk("hold_bidx", best_idx_o, 1);
    chk("hold_bsad", best_sad_o, 12);
    chk("hold_busy", busy_o, 0);

    start_search(5, 5, 5, 5, 1);
    wait_done();
    start_search(SAD_ONES, SAD_ONES, SAD_ONES, SAD_ONES, 1);
    wait_done();

    start_search(7, 3, 8, 2, 1);
    wait_cand(2'd1);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done();
    repeat (5) @(negedge clk_i);
    chk("run_start_ign", busy_o, 0);

    start_search(6, 9, 4, 4, 1);
    wait_done();
    start_i = 1'b1;
    @(negedge clk_i);
    chk("done_start_ign", busy_o, 0);
    sads = '{2, 1, 1, 3};
    q.push_back(model());
    @(negedge clk_i);
    start_i = 1'b0;
    chk("next_start_acc", busy_o, 1);
    wait_done();

    start_search(50, 40, 30, 20, 0);
    wait_cand(2'd2);
    d0 = done_cnt;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk_reset_vals("abort");
    rst_i = 1'b0;
    repeat (300) @(negedge clk_i);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle", busy_o, 0);

    start_search(9, 0, 3, 1, 1);
    wait_done();
    repeat (5) @(negedge clk_i);
    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
